// File: rtl/pool_stream_kxk.sv
// Streaming KxK, stride-K pooling unit.
// Pixels arrive one per beat in row-major order. A line buffer keeps one
// partial result per output column. One pooled value is emitted per window.
// Max pooling is always built. Defining POOL_AVG_EN adds average pooling,
// which is selected per frame by pool_mode.
module pool_stream_kxk #(
  parameter int DATA_W = 16,
  parameter int K      = 2,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              pool_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int LOG2K = $clog2(K);
`ifdef POOL_AVG_EN
  localparam int ACC_W = DATA_W + 2 * LOG2K;
`else
  localparam int ACC_W = DATA_W;
`endif
  localparam int NB  = IMG_W / K;
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1;

  // Reject geometries the counters and window decode cannot handle.
  generate
    if ((K < 2) || (K > 8) || ((K & (K - 1)) != 0)) begin : g_bad_k
      $error("pool_stream_kxk: K must be a power of two in 2..8");
    end
    if ((IMG_W % K) != 0) begin : g_bad_w
      $error("pool_stream_kxk: IMG_W must be a multiple of K");
    end
    if ((IMG_H % K) != 0) begin : g_bad_h
      $error("pool_stream_kxk: IMG_H must be a multiple of K");
    end
  endgenerate

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic [ACC_W-1:0]  buf_mem [NB];
  logic              buf_we_s;
  logic [ACC_W-1:0]  buf_wdata_s;
  logic [BIW-1:0]    idx_s;
  logic [ACC_W-1:0]  entry_s;
  logic [ACC_W-1:0]  pix_ext_s;
  logic signed [ACC_W-1:0] comb_s;
  logic [DATA_W-1:0] result_s;

  logic hs_s;
  logic col_last_s;
  logic row_last_s;
  logic win_first_s;
  logic win_last_s;
  logic frame_first_s;
  logic frame_end_s;
  logic mode_s;

  assign in_ready  = !out_valid_q | out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  assign hs_s          = in_valid & in_ready;
  assign col_last_s    = (col_q == CW'(IMG_W - 1));
  assign row_last_s    = (row_q == RW'(IMG_H - 1));
  assign win_first_s   = (col_q[LOG2K-1:0] == {LOG2K{1'b0}}) && (row_q[LOG2K-1:0] == {LOG2K{1'b0}});
  assign win_last_s    = (&col_q[LOG2K-1:0]) && (&row_q[LOG2K-1:0]);
  assign frame_first_s = (col_q == {CW{1'b0}}) && (row_q == {RW{1'b0}});
  assign frame_end_s   = col_last_s && row_last_s;

  assign idx_s     = BIW'(col_q >> LOG2K);
  assign entry_s   = buf_mem[idx_s];
  assign pix_ext_s = {{(ACC_W - DATA_W){in_data[DATA_W-1]}}, in_data};

`ifdef POOL_AVG_EN
  logic mode_q, mode_d;
  assign mode_s = mode_q;

  // Frame mode register: captured with the first pixel of each frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Next frame mode: only the (0,0) handshake reloads it; clr leaves it alone.
  always_comb begin
    mode_d = mode_q;
    if (!clr && hs_s && frame_first_s) begin
      mode_d = pool_mode;
    end else begin
      mode_d = mode_q;
    end
  end

  // Combine the incoming pixel with the column entry and form the result.
  always_comb begin
    comb_s   = $signed(entry_s);
    result_s = entry_s[DATA_W-1:0];
    if (mode_s) begin
      comb_s   = $signed(entry_s) + $signed(pix_ext_s);
      result_s = DATA_W'(comb_s >>> (2 * LOG2K));
    end else begin
      if ($signed(pix_ext_s) > $signed(entry_s)) begin
        comb_s = $signed(pix_ext_s);
      end else begin
        comb_s = $signed(entry_s);
      end
      result_s = comb_s[DATA_W-1:0];
    end
  end
`else
  logic unused_mode_s;
  assign unused_mode_s = pool_mode;
  assign mode_s        = 1'b0;

  // Max-only combine: keep the larger of pixel and column entry.
  always_comb begin
    comb_s   = $signed(entry_s);
    result_s = entry_s;
    if (!mode_s && ($signed(pix_ext_s) > $signed(entry_s))) begin
      comb_s = $signed(pix_ext_s);
    end else begin
      comb_s = $signed(entry_s);
    end
    result_s = comb_s[DATA_W-1:0];
  end
`endif

  // Next-state for counters, output register and line-buffer write.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    buf_we_s    = 1'b0;
    buf_wdata_s = comb_s;
    if (clr) begin
      col_d       = {CW{1'b0}};
      row_d       = {RW{1'b0}};
      out_valid_d = 1'b0;
    end else begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      if (hs_s) begin
        if (col_last_s) begin
          col_d = {CW{1'b0}};
          if (row_last_s) begin
            row_d = {RW{1'b0}};
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
          row_d = row_q;
        end
        if (win_last_s) begin
          // Finished window goes straight to the output; entry is not written back.
          out_valid_d = 1'b1;
          out_data_d  = result_s;
          out_last_d  = frame_end_s;
        end else if (win_first_s) begin
          // First pixel of a window overwrites stale contents, so no buffer init is needed.
          buf_we_s    = 1'b1;
          buf_wdata_s = pix_ext_s;
        end else begin
          buf_we_s    = 1'b1;
          buf_wdata_s = comb_s;
        end
      end else begin
        col_d = col_q;
        row_d = row_q;
      end
    end
  end

  // State registers; reset drops any pending result at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= {CW{1'b0}};
      row_q       <= {RW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {1'b1, {(DATA_W - 1){1'b0}}};
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffer: one partial window result per output column, no reset needed.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      buf_mem[idx_s] <= buf_wdata_s;
    end
  end

endmodule

// File: tb/tb_pool_stream_kxk.sv
// Scoreboard bench for pool_stream_kxk (K=2, 4x2 frames).
// The reference model stores each frame as a 2-D array and computes each
// window's max or floor average directly from the pixels.
module tb_pool_stream_kxk;
  localparam int DW = 16;
  localparam int K  = 2;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NP = W * H;

  logic clk = 1'b0;
  logic rst, clr, pool_mode, in_valid, in_ready;
  logic out_valid, out_ready, out_last;
  logic [DW-1:0] in_data, out_data;

  pool_stream_kxk #(.DATA_W(DW), .K(K), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .clr(clr), .pool_mode(pool_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   p = 0;
  logic fmode = 1'b0;
  int   pix [H][W];
  int   ready_mode = 0;
  bit   held = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: record the accepted pixel, emit expectation on window completion.
  task automatic model_accept(input logic [DW-1:0] d, input logic mode);
    int r, c, best, sum, q;
    exp_t e;
    r = p / W;
    c = p % W;
    if (p == 0) begin
`ifdef POOL_AVG_EN
      fmode = mode;
`else
      fmode = mode & 1'b0;
`endif
    end
    pix[r][c] = int'($signed(d));
    if ((r % K == K - 1) && (c % K == K - 1)) begin
      best = pix[r][c];
      sum  = 0;
      for (int i = r - K + 1; i <= r; i++) begin
        for (int j = c - K + 1; j <= c; j++) begin
          if (pix[i][j] > best) best = pix[i][j];
          sum += pix[i][j];
        end
      end
      q = sum / (K * K);
      if ((sum % (K * K) != 0) && (sum < 0)) q = q - 1;
      e.data = fmode ? q[DW-1:0] : best[DW-1:0];
      e.last = (p == NP - 1);
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    p = (p + 1) % NP;
  endtask

  // Drive one pixel; starts and ends just after a rising edge.
  task automatic send_px(input logic [DW-1:0] d, input logic mode);
    int waitc;
    in_data   = d;
    pool_mode = mode;
    in_valid  = 1'b1;
    waitc     = 0;
    @(negedge clk);
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL in_handshake_timeout: got in_ready 0 expected 1 within 200 cycles");
    end else begin
      model_accept(d, mode);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send pixels [first, last) of a frame; optional mid-frame mode toggle and gaps.
  task automatic send_part(input logic [DW-1:0] v[NP], input int first, input int last,
                           input logic mode, input bit toggle, input bit gaps);
    for (int i = first; i < last; i++) begin
      send_px(v[i], (toggle && i >= 3) ? ~mode : mode);
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask

  // Output driver for out_ready: 0 = always ready, 1 = random, other = held low.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare every presented output with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        chk("in_ready_rule", 32'(in_ready), 32'(!out_valid | out_ready));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got data %0h with nothing expected", out_data);
          end else begin
            chk("out_data", 32'(out_data), 32'(exp_q[0].data));
            chk("out_last", 32'(out_last), 32'(exp_q[0].last));
            if (!held) chk("out_latency_cycle", 32'(cyc), 32'(exp_q[0].cyc));
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        held = out_valid && !out_ready;
      end
    end
  end

  logic [DW-1:0] f_base [NP];
  logic [DW-1:0] f_neg  [NP];
  logic [DW-1:0] f_min  [NP];
  logic [DW-1:0] f_max  [NP];
  logic [DW-1:0] f_rnd  [NP];

  initial begin
    logic [DW-1:0] d0;
    int t;
    f_base = '{16'd1, 16'hFFFB, 16'd7, 16'd3, 16'd4, 16'd2, 16'hFFF8, 16'd9};
    f_neg  = '{16'hFFFF, 16'hFFFE, 16'd5, 16'd6, 16'hFFFF, 16'hFFFF, 16'd0, 16'd3};
    for (int i = 0; i < NP; i++) begin
      f_min[i] = 16'h8000;
      f_max[i] = 16'h7FFF;
    end

    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 16'h0000; pool_mode = 1'b0;
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_out_data",  32'(out_data),  32'h8000);
    chk("reset_out_last",  32'(out_last),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed frames: max, average, negative-floor average.
    send_part(f_base, 0, NP, 1'b0, 1'b0, 1'b0);
    send_part(f_base, 0, NP, 1'b1, 1'b0, 1'b0);
    send_part(f_neg,  0, NP, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Backpressure: first output held for 5 cycles.
    ready_mode = 2;
    idle(1);
    fork
      send_part(f_base, 0, NP, 1'b0, 1'b0, 1'b0);
      begin
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 100) begin
          @(negedge clk);
          t++;
        end
        if (!out_valid) begin
          n_checks++;
          n_errors++;
          $display("FAIL bp_wait_timeout: got out_valid 0 expected 1");
        end else begin
          d0 = out_data;
          repeat (5) begin
            chk("bp_data_stable", 32'(out_data), 32'(d0));
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            @(negedge clk);
          end
        end
        ready_mode = 0;
      end
    join
    idle(3);

    // Mode switch mid-frame, both directions.
    send_part(f_base, 0, NP, 1'b1, 1'b1, 1'b0);
    send_part(f_base, 0, NP, 1'b0, 1'b1, 1'b0);

    // Extremes in both modes.
    send_part(f_min, 0, NP, 1'b0, 1'b0, 1'b0);
    send_part(f_max, 0, NP, 1'b1, 1'b0, 1'b0);
    send_part(f_min, 0, NP, 1'b1, 1'b0, 1'b0);
    send_part(f_max, 0, NP, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Abort by rst after 3 pixels.
    send_part(f_neg, 0, 3, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_abort_out_valid", 32'(out_valid), 32'd0);
    chk("rst_abort_in_ready",  32'(in_ready),  32'd1);
    chk("rst_abort_out_data",  32'(out_data),  32'h8000);
    p = 0; fmode = 1'b0; exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_part(f_base, 0, NP, 1'b0, 1'b0, 1'b0);

    // Abort by clr after 3 pixels, with a same-cycle pixel that must be discarded.
    send_part(f_neg, 0, 3, 1'b1, 1'b0, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_data = 16'h7777;
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    p = 0; exp_q.delete();
    chk("clr_abort_out_valid", 32'(out_valid), 32'd0);
    send_part(f_base, 0, NP, 1'b1, 1'b0, 1'b0);

    // clr while a result is held: it must be dropped.
    ready_mode = 2;
    idle(1);
    send_part(f_neg, 0, 6, 1'b0, 1'b0, 1'b0);
    chk("clr_pending_valid_before", 32'(out_valid), 32'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    p = 0; exp_q.delete();
    chk("clr_pending_dropped", 32'(out_valid), 32'd0);
    ready_mode = 0;
    send_part(f_neg, 0, NP, 1'b0, 1'b0, 1'b0);

    // Randomized frames with random backpressure, gaps and mode toggles.
    ready_mode = 1;
    for (int fr = 0; fr < 20; fr++) begin
      for (int i = 0; i < NP; i++) begin
        case ($urandom_range(0, 3))
          0:       f_rnd[i] = 16'h8000;
          1:       f_rnd[i] = 16'h7FFF;
          default: f_rnd[i] = 16'($urandom);
        endcase
      end
      send_part(f_rnd, 0, NP, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    // Drain.
    ready_mode = 0;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d outputs outstanding expected 0", exp_q.size());
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pool_stream_kxk.md
# pool_stream_kxk

Streaming K×K, stride-K pooling unit for the CNN feature-map path, replacing fixed 2×2 pair-compare pooling. Accepts one signed pixel per beat in row-major order over a valid/ready handshake. Keeps per-output-column partial results in an internal line buffer. Emits one pooled value per completed window with frame-end marking. Max pooling is always present; average pooling is a compile-time option.

## Interface
Parameters:
- DATA_W, 16, pixel and result width (signed two's complement)
- K, 2, window size and stride; power of two, 2..8
- IMG_W, 24, input row length in pixels; multiple of K (elaboration error otherwise)
- IMG_H, 24, input rows per frame; multiple of K (elaboration error otherwise)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous frame abort: counters to 0, out_valid to 0
- pool_mode  in  1  0 = max, 1 = average; sampled only at frame start
- in_valid  in  1  input pixel valid
- in_ready  out  1  input accepted when in_valid & in_ready
- in_data  in  DATA_W  signed input pixel
- out_valid  out  1  pooled result valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  signed pooled result
- out_last  out  1  high with the final result of a frame

## Operation
- Counters: col (0..IMG_W-1), row (0..IMG_H-1). Both advance only on an input handshake. col wraps to 0 at IMG_W-1 and row increments. At row IMG_H-1 / col IMG_W-1, both wrap to 0 (next frame).
- Line buffer: IMG_W/K entries of ACC_W = DATA_W + 2·log2(K) bits, indexed by col/K.
- Window-first pixel (row%K==0 and col%K==0): entry is loaded with the pixel. It is not combined, so no buffer initialisation is needed.
- Other pixels combine into the entry:
  - max mode: signed greater-than compare.
  - avg mode: sign-extended add.
- Window-last pixel (row%K==K-1 and col%K==K-1): the combined value is written to the output register and out_valid is set. The buffer entry is not written back.
- Avg result: sum arithmetic-shifted right by 2·log2(K), i.e. floor division, then truncated to DATA_W. Max result: low DATA_W bits of the entry.
- Mode latch: pool_mode is captured on the handshake of pixel (0,0) and held for the whole frame. Mid-frame changes are ignored.
- out_last = 1 when the emitted window ends at (IMG_H-1, IMG_W-1).
- clr: counters return to 0 and out_valid clears. Buffer contents are left as-is (overwritten by window-first loads). clr has priority over a same-cycle handshake, and that input is discarded.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 16'h8000 (most negative, DATA_W-wide), out_last 0, counters 0, latched mode 0.
- in_ready = !out_valid | out_ready (combinational).
- Output lands one cycle after the window-last handshake.
- Simultaneous output accept and new window-last input: out_valid stays 1 and data is replaced. Full throughput, no bubble.
- out_valid & !out_ready: out_data and out_last hold stable, and input stalls (in_ready 0).
- Non-window-last pixels are never stalled unless the output is blocked.
- rst mid-frame: all state returns to reset values immediately and any pending result is dropped.

## Configuration
- POOL_AVG_EN defined: average path, ACC_W accumulator width, and mode latch are built.
- POOL_AVG_EN undefined:
  - pool_mode is ignored and the unit is max-only.
  - Buffer entries are DATA_W wide.
  - The adder and shifter are absent.

## Test plan
- Max, K=2, IMG_W=4, IMG_H=2, rows [1,-5,7,3] / [4,2,-8,9], out_ready=1 -> outputs 4 then 9. out_last=1 on 9. Each output arrives 1 cycle after its last pixel.
- Avg (POOL_AVG_EN), same frame -> 0 then 2. Rerun with [-1,-2,…] / [-1,-1,…] in the first window -> -2 (floor of -5/4).
- Backpressure: hold out_ready=0 for 5 cycles after the first output -> out_data stable, in_ready=0, no pixel lost. Final outputs are unchanged.
- Mode switch: toggle pool_mode mid-frame -> the frame uses its start mode. The next frame uses the new mode.
- Extremes: all pixels 16'h8000 (max) -> 16'h8000. All 16'h7FFF (avg) -> 16'h7FFF, no overflow.
- Abort: assert rst, or separately clr, after 3 pixels of the frame, then send a full frame -> correct results only for the new frame; out_valid 0 during the abort cycle.
